shiftout_chain: RTL and testbench

Parametrised serial driver for daisy-chained 74HC595-style shift registers. It accepts a parallel word through a valid/ready handshake and shifts it out MSB- or LSB-first on a divided serial clock. After the last bit it pulses the latch, then signals completion. It sits between user logic (counters, display drivers) and the board's shift-register header, and replaces free-running, fixed 8-bit shift-out logic.

---
 rtl/shiftout_chain.sv | 154 +++++++++++++++
 tb/tb_shiftout_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftout_chain.sv
// Serial driver for daisy-chained 74HC595-style shift registers: accepts a
// parallel word via valid/ready, shifts it out on a divided clock, then latches.
module shiftout_chain #(
    parameter int WIDTH        = 8,
    parameter int CHAIN        = 1,
    parameter int DIV          = 2,
    parameter int MSB_FIRST    = 1,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                   clk_25MHz,
    input  logic                   reset,
    input  logic [WIDTH*CHAIN-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   shiftout_clock,
    output logic                   shiftout_data,
    output logic                   shiftout_latch,
    output logic                   busy,
    output logic                   done
);

    localparam int N  = WIDTH * CHAIN;
    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(N + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LOAD = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(N);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(LATCH_CYCLES - 1);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   sreg, sreg_nxt, sreg_shifted;
    logic [DW-1:0]  div_cnt, div_nxt;
    logic [BW-1:0]  bit_cnt, bit_nxt;
    logic [LW-1:0]  lat_cnt, lat_nxt;
    logic           ready_nxt, sclk_nxt, sdat_nxt, latch_nxt, busy_nxt, done_nxt;

    function automatic logic head(input logic [N-1:0] v);
        return (MSB_FIRST != 0) ? v[N-1] : v[0];
    endfunction

    always_comb begin
        if (MSB_FIRST != 0) sreg_shifted = sreg << 1;
        else                sreg_shifted = sreg >> 1;
    end

    // Every output is computed one cycle ahead so the header pins come straight from flops.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        lat_nxt   = lat_cnt;
        ready_nxt = ready;
        sclk_nxt  = shiftout_clock;
        sdat_nxt  = shiftout_data;
        latch_nxt = shiftout_latch;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = data;
                    bit_nxt   = BIT_LOAD;
                    div_nxt   = DIV_LOAD;
                    sclk_nxt  = 1'b0;
                    sdat_nxt  = head(data);
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt != '0) begin
                    div_nxt = div_cnt - DIV_ONE;
                end else begin
                    div_nxt = DIV_LOAD;
                    if (!shiftout_clock) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        bit_nxt  = bit_cnt - BIT_ONE;
                        if (bit_cnt == BIT_ONE) begin
                            // Last bit stays on the data pin through the latch pulse.
                            state_nxt = LATCH;
                            latch_nxt = 1'b1;
                            lat_nxt   = LAT_LOAD;
                        end else begin
                            sreg_nxt = sreg_shifted;
                            sdat_nxt = head(sreg_shifted);
                        end
                    end
                end
            end
            LATCH: begin
                if (lat_cnt != '0) begin
                    lat_nxt = lat_cnt - LAT_ONE;
                end else begin
                    state_nxt = IDLE;
                    latch_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                latch_nxt = 1'b0;
                sclk_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sreg           <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            lat_cnt        <= '0;
            ready          <= 1'b1;
            shiftout_clock <= 1'b0;
            shiftout_data  <= 1'b0;
            shiftout_latch <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            sreg           <= sreg_nxt;
            div_cnt        <= div_nxt;
            bit_cnt        <= bit_nxt;
            lat_cnt        <= lat_nxt;
            ready          <= ready_nxt;
            shiftout_clock <= sclk_nxt;
            shiftout_data  <= sdat_nxt;
            shiftout_latch <= latch_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shiftout_chain.sv
// Bench for shiftout_chain: three configurations driven side by side, each
// feeding a behavioural model of chained 595s (shift on SRCLK rise, copy on RCLK rise).
module tb_shiftout_chain;

    localparam int LCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  valid = '0;
    logic [7:0]  d0 = '0, d1 = '0;
    logic [15:0] d2 = '0;
    logic [2:0]  ready, sclk, sdat, slat, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural 595 chain model and protocol observers, one slot per instance.
    logic [15:0] sr [3];
    logic [15:0] st [3];
    int          edges_w [3];
    int          acc_cyc [3];
    int          done_cyc [3];
    int          done_cnt [3];
    int          lat_start [3];
    int          lat_cnt [3];
    int          lat_run [3];
    int          low_run [3];
    int          high_run [3];
    int          viol [3];
    logic [2:0]  p_sclk = '0, p_sdat = '0, p_slat = '0, p_done = '0;

    shiftout_chain #(.WIDTH(8), .CHAIN(1), .DIV(2), .MSB_FIRST(1), .LATCH_CYCLES(LCY)) u0 (
        .clk_25MHz(clk), .reset(rst), .data(d0), .valid(valid[0]), .ready(ready[0]),
        .shiftout_clock(sclk[0]), .shiftout_data(sdat[0]), .shiftout_latch(slat[0]),
        .busy(busy[0]), .done(done[0]));

    shiftout_chain #(.WIDTH(8), .CHAIN(1), .DIV(2), .MSB_FIRST(0), .LATCH_CYCLES(LCY)) u1 (
        .clk_25MHz(clk), .reset(rst), .data(d1), .valid(valid[1]), .ready(ready[1]),
        .shiftout_clock(sclk[1]), .shiftout_data(sdat[1]), .shiftout_latch(slat[1]),
        .busy(busy[1]), .done(done[1]));

    shiftout_chain #(.WIDTH(8), .CHAIN(2), .DIV(1), .MSB_FIRST(1), .LATCH_CYCLES(LCY)) u2 (
        .clk_25MHz(clk), .reset(rst), .data(d2), .valid(valid[2]), .ready(ready[2]),
        .shiftout_clock(sclk[2]), .shiftout_data(sdat[2]), .shiftout_latch(slat[2]),
        .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int g); return (g == 2) ? 1 : 2;   endfunction
    function automatic int n_of(input int g);   return (g == 2) ? 16 : 8;  endfunction
    function automatic logic [15:0] mask_of(input int g);
        return (g == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    // What the chain should hold after a word: first bit sent lands at the far end.
    function automatic logic [15:0] exp_latched(input int g, input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < n_of(g); k++) begin
            if (g != 1) r[k] = w[k];
            else        r[n_of(g) - 1 - k] = w[k];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            p_sclk[g] <= sclk[g];
            p_sdat[g] <= sdat[g];
            p_slat[g] <= slat[g];
            p_done[g] <= done[g];
            if (rst) begin
                low_run[g]  <= 0;
                high_run[g] <= 0;
                lat_run[g]  <= 0;
            end else begin
                if (valid[g] && ready[g]) begin
                    acc_cyc[g] <= cyc;
                    edges_w[g] <= 0;
                end
                if (sclk[g] && !p_sclk[g]) begin
                    sr[g]       <= {sr[g][14:0], sdat[g]};
                    edges_w[g]  <= edges_w[g] + 1;
                    high_run[g] <= 1;
                    if (low_run[g] != div_of(g)) viol[g] <= viol[g] + 1;
                end else if (sclk[g]) begin
                    high_run[g] <= high_run[g] + 1;
                end
                if (sclk[g] && (sdat[g] != p_sdat[g])) viol[g] <= viol[g] + 1;
                if (!sclk[g]) begin
                    if (!busy[g])     low_run[g] <= 0;
                    else if (p_sclk[g]) low_run[g] <= 1;
                    else              low_run[g] <= low_run[g] + 1;
                    if (p_sclk[g] && (high_run[g] != div_of(g))) viol[g] <= viol[g] + 1;
                end
                if (slat[g]) begin
                    lat_run[g] <= lat_run[g] + 1;
                    if (sclk[g]) viol[g] <= viol[g] + 1;
                    if (!p_slat[g]) begin
                        lat_start[g] <= cyc;
                        lat_cnt[g]   <= lat_cnt[g] + 1;
                        st[g]        <= sr[g];
                    end
                end else if (p_slat[g]) begin
                    lat_run[g] <= 0;
                    if (lat_run[g] != LCY) viol[g] <= viol[g] + 1;
                end
                if (done[g]) begin
                    done_cnt[g] <= done_cnt[g] + 1;
                    done_cyc[g] <= cyc;
                    if (p_done[g]) viol[g] <= viol[g] + 1;
                end
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int g, input logic v, input logic [15:0] w);
        valid[g] = v;
        case (g)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            default: d2 = w;
        endcase
    endtask

    task automatic wait_done(input int g, input int start, input int budget, input string nm);
        int n;
        n = 0;
        while (done_cnt[g] == start && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_done"}, done_cnt[g] - start, 1);
    endtask

    // One word on instance g; optional stray valid pulse while busy.
    task automatic run_word(input int g, input logic [15:0] w, input logic [15:0] exp,
                            input string nm, input int pulse_at);
        int s, n;
        n = 0;
        while (!ready[g] && n < 100) begin
            tick();
            n++;
        end
        s = done_cnt[g];
        set_in(g, 1'b1, w);
        tick();
        set_in(g, 1'b0, w);
        if (pulse_at > 0) begin
            repeat (pulse_at) tick();
            set_in(g, 1'b1, ~w);
            tick();
            set_in(g, 1'b0, w);
        end
        wait_done(g, s, 300, nm);
        check({nm, "_latched"}, st[g] & mask_of(g), exp);
        check({nm, "_edges"}, edges_w[g], n_of(g));
        check({nm, "_period"}, done_cyc[g] - acc_cyc[g], 1 + 2 * div_of(g) * n_of(g) + LCY);
        check({nm, "_latch_start"}, lat_start[g] - acc_cyc[g], 1 + 2 * div_of(g) * n_of(g));
        repeat (6) tick();
        check({nm, "_one_done"}, done_cnt[g] - s, 1);
    endtask

    typedef struct {
        int          g;
        logic [15:0] w;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   s, n, d1c, s_lat, s_done, g;
        logic [15:0] w;

        tbl[0] = '{0, 16'h00A5, 16'h00A5};
        tbl[1] = '{1, 16'h00A5, 16'h00A5};
        tbl[2] = '{1, 16'h0001, 16'h0080};
        tbl[3] = '{0, 16'h0001, 16'h0001};
        tbl[4] = '{1, 16'h0003, 16'h00C0};
        tbl[5] = '{2, 16'h1234, 16'h1234};
        tbl[6] = '{2, 16'h8001, 16'h8001};

        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outs_%0d", i), {sclk[i], sdat[i], slat[i], busy[i], done[i]}, 0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", ready, 3'b111);

        for (int i = 0; i < 7; i++)
            run_word(tbl[i].g, tbl[i].w, tbl[i].exp, $sformatf("vec%0d", i), 0);

        // Stray valid with another word while busy must be ignored.
        run_word(0, 16'h005A, 16'h005A, "busy_ignore", 3);

        // Back-to-back on the 2-register chain with valid held high.
        s = done_cnt[2];
        set_in(2, 1'b1, 16'h1234);
        wait_done(2, s, 200, "b2b_first");
        check("b2b_first_latched", st[2], 16'h1234);
        check("b2b_accept_on_done", acc_cyc[2], done_cyc[2]);
        d1c = done_cyc[2];
        set_in(2, 1'b1, 16'hBEEF);
        s = done_cnt[2];
        wait_done(2, s, 200, "b2b_second");
        check("b2b_second_latched", st[2], 16'h1234);
        check("b2b_word_period", done_cyc[2] - d1c, 35);
        set_in(2, 1'b0, 16'hBEEF);
        s = done_cnt[2];
        wait_done(2, s, 200, "b2b_third");
        check("b2b_third_latched", st[2], 16'hBEEF);

        // Reset in the middle of a word, at the 5th serial clock edge.
        repeat (3) tick();
        s_lat  = lat_cnt[0];
        s_done = done_cnt[0];
        set_in(0, 1'b1, 16'h00F0);
        tick();
        set_in(0, 1'b0, 16'h00F0);
        n = 0;
        while (edges_w[0] < 5 && n < 200) begin
            tick();
            n++;
        end
        check("mid_edge5_reached", edges_w[0], 5);
        rst = 1'b1;
        #1;
        check("mid_reset_outs", {sclk[0], sdat[0], slat[0], busy[0], done[0]}, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("mid_no_latch", lat_cnt[0] - s_lat, 0);
        check("mid_no_done", done_cnt[0] - s_done, 0);
        run_word(0, 16'h003C, 16'h003C, "after_reset", 0);

        // Randomised words across all three configurations.
        for (int it = 0; it < 24; it++) begin
            g = $urandom_range(0, 2);
            w = 16'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_word(g, w, exp_latched(g, w), $sformatf("rnd%0d", it),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0);
        end

        for (int i = 0; i < 3; i++)
            check($sformatf("protocol_%0d", i), viol[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
